// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, scan state type and digit helper for the display scanner
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_e;

  // Index of the most significant nonzero nibble; 0 when the whole value is zero
  function automatic logic [2:0] msd_index(input logic [31:0] value);
    msd_index = 3'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (value[4*i +: 4] != 4'd0) msd_index = 3'(i);
    end
  endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// rtl/seg_scan_controller_if.sv - display data load handshake between requester and scanner
interface seg_scan_controller_if;

  logic [31:0] value_in;
  logic [7:0]  dp_in;
  logic        load_req;
  logic        load_ack;

  modport master (output value_in, output dp_in, output load_req, input load_ack);
  modport slave  (input value_in, input dp_in, input load_req, output load_ack);

endinterface

// File: rtl/seg_slot_timer.sv
// rtl/seg_slot_timer.sv - per-digit slot counter with end-of-blank and end-of-slot strobes
module seg_slot_timer #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic blank_done,
  output logic slot_end
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] count;

  // Strobes look one cycle ahead so the caller's registers change together with the counter
  assign blank_done = (count == BLANK_LAST);
  assign slot_end   = (count == SLOT_LAST);

  // Free-running slot counter, wraps at the end of every digit slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (slot_end) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - 8-digit multiplexed seven-segment scanner with frame-aligned loads
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  seg_scan_controller_if.slave        load_bus,
  input  logic [7:0]                  digit_en,
  input  logic                        lz_blank,
  output logic [3:0]                  digit_bin,
  output logic                        dp_out,
  output logic                        seg_blank,
  output logic [7:0]                  Anode,
  output logic                        frame_start
);

  logic        blank_done;
  logic        slot_end;
  scan_state_e state;
  scan_state_e state_nx;
  logic [2:0]  idx;
  logic [2:0]  idx_nx;
  logic [31:0] shadow;
  logic [31:0] shadow_nx;
  logic [7:0]  dp_shadow;
  logic [7:0]  dp_nx;
  logic [2:0]  msd;
  logic [3:0]  nib;
  logic        show;
  logic        boundary;
  logic        take_load;

  seg_slot_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .blank_done (blank_done),
    .slot_end   (slot_end)
  );

  // Last cycle of the final digit's slot is the only point where new data may enter
  assign boundary  = slot_end && (idx == 3'(NUM_DIGITS - 1));
  assign take_load = boundary && load_bus.load_req;

  // Next-cycle scan position and digit visibility, so outputs register in step with the timer
  always_comb begin
    idx_nx    = slot_end ? idx + 3'd1 : idx;
    state_nx  = state;
    if (slot_end) begin
      state_nx = BLANK;
    end else if (blank_done) begin
      state_nx = ON;
    end
    shadow_nx = shadow;
    dp_nx     = dp_shadow;
    if (take_load) begin
      shadow_nx = load_bus.value_in;
      dp_nx     = load_bus.dp_in;
    end
    msd  = msd_index(shadow_nx);
    nib  = shadow_nx[{idx_nx, 2'b00} +: 4];
    show = digit_en[idx_nx] && !(lz_blank && (idx_nx > msd) && !dp_nx[idx_nx]);
  end

  // Scan FSM, shadow registers, handshake and all registered display outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= BLANK;
      idx               <= 3'd0;
      shadow            <= 32'd0;
      dp_shadow         <= 8'd0;
      Anode             <= ANODE_OFF;
      digit_bin         <= 4'd0;
      dp_out            <= 1'b0;
      seg_blank         <= 1'b1;
      load_bus.load_ack <= 1'b0;
      frame_start       <= 1'b0;
    end else begin
      state             <= state_nx;
      idx               <= idx_nx;
      shadow            <= shadow_nx;
      dp_shadow         <= dp_nx;
      load_bus.load_ack <= take_load;
      frame_start       <= boundary;
      if (state_nx == ON) begin
        Anode     <= show ? ~(8'd1 << idx_nx) : ANODE_OFF;
        digit_bin <= nib;
        dp_out    <= dp_nx[idx_nx];
        seg_blank <= !show;
      end else begin
        Anode     <= ANODE_OFF;
        digit_bin <= 4'd0;
        dp_out    <= 1'b0;
        seg_blank <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - randomized self-checking bench for seg_scan_controller
module tb_seg_scan_controller;

  localparam int DC = 10;
  localparam int BC = 2;
  localparam int FRAME = DC * 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] digit_en = 8'hFF;
  logic       lz_blank = 1'b0;
  logic [3:0] digit_bin;
  logic       dp_out;
  logic       seg_blank;
  logic [7:0] Anode;
  logic       frame_start;

  int errors = 0;
  int checks = 0;

  seg_scan_controller_if bus ();

  seg_scan_controller #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_bus    (bus),
    .digit_en    (digit_en),
    .lz_blank    (lz_blank),
    .digit_bin   (digit_bin),
    .dp_out      (dp_out),
    .seg_blank   (seg_blank),
    .Anode       (Anode),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {Anode, digit_bin, dp_out, seg_blank, bus.load_ack, frame_start};

  // Reference model: absolute cycle count since reset determines slot and phase
  int          k = 0;
  logic [31:0] m_shadow = 32'd0;
  logic [7:0]  m_dp = 8'd0;
  logic [15:0] exp_vec = 16'hFF04;

  function automatic int top_digit(input logic [31:0] v);
    for (int i = 7; i > 0; i--) begin
      if (((v >> (4 * i)) & 32'hF) != 32'd0) return i;
    end
    return 0;
  endfunction

  // Advance the model one clock and derive the expected output word
  always @(posedge clk) begin
    int   slot;
    int   off;
    logic ack;
    logic vis;
    logic [3:0] nib;
    if (!reset) begin
      k = 0;
      m_shadow = 32'd0;
      m_dp = 8'd0;
      exp_vec = 16'hFF04;
    end else begin
      ack = ((k % FRAME) == FRAME - 1) && bus.load_req;
      if (ack) begin
        m_shadow = bus.value_in;
        m_dp = bus.dp_in;
      end
      k++;
      slot = (k / DC) % 8;
      off = k % DC;
      nib = 4'((m_shadow >> (4 * slot)) & 32'hF);
      if (off < BC) begin
        exp_vec = {8'hFF, 4'h0, 1'b0, 1'b1, ack, (k % FRAME) == 0};
      end else begin
        vis = digit_en[slot] && !(lz_blank && slot > top_digit(m_shadow) && !m_dp[slot]);
        exp_vec = {vis ? ~(8'd1 << slot) : 8'hFF, nib, m_dp[slot], !vis, ack, (k % FRAME) == 0};
      end
    end
  end

  task automatic do_load(input logic [31:0] v, input logic [7:0] d);
    bit got = 0;
    @(negedge clk);
    bus.value_in = v;
    bus.dp_in = d;
    bus.load_req = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.load_ack === 1'b1) got = 1;
    end
    bus.load_req = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL load_timeout: ack=0 required 1 within 200 cycles"); end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.value_in = 32'hA5A5A5A5;
    bus.dp_in = 8'hFF;
    bus.load_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (Anode !== 8'hFF) begin errors++; $display("FAIL reset_anode: got %h required ff", Anode); end
    checks++; if (digit_bin !== 4'h0) begin errors++; $display("FAIL reset_digit_bin: got %h required 0", digit_bin); end
    checks++; if (dp_out !== 1'b0) begin errors++; $display("FAIL reset_dp: got %b required 0", dp_out); end
    checks++; if (seg_blank !== 1'b1) begin errors++; $display("FAIL reset_seg_blank: got %b required 1", seg_blank); end
    checks++; if (bus.load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", bus.load_ack); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b required 0", frame_start); end
    bus.load_req = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_scan_timing;
    int fs = 0;
    digit_en = 8'hFF;
    lz_blank = 1'b0;
    do_load(32'h76543210, 8'h00);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++; if (obs !== exp_vec) begin errors++; $display("FAIL scan k=%0d got=%h required=%h", k, obs, exp_vec); end
      if (((i + 1) % DC) >= BC) begin
        checks++;
        if (digit_bin !== 4'(((i + 1) / DC) % 8)) begin errors++; $display("FAIL scan_digit k=%0d got=%h required=%0d", k, digit_bin, ((i + 1) / DC) % 8); end
      end
      if (frame_start === 1'b1) begin
        fs++;
        checks++; if (((i + 1) % FRAME) != 0) begin errors++; $display("FAIL frame_period: pulse at offset %0d required multiple of %0d", i + 1, FRAME); end
      end
    end
    checks++; if (fs != 2) begin errors++; $display("FAIL frame_count: got %0d required 2", fs); end
  endtask

  task automatic test_load_timing;
    bit got = 0;
    for (int i = 0; i < 200 && (k % FRAME) != 30; i++) @(negedge clk);
    bus.value_in = 32'hDEADBEEF;
    bus.dp_in = 8'h00;
    bus.load_req = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      checks++; if (obs !== exp_vec) begin errors++; $display("FAIL load_old k=%0d got=%h required=%h", k, obs, exp_vec); end
      if (bus.load_ack === 1'b1) begin
        got = 1;
        bus.load_req = 1'b0;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL ack_frame: frame_start=%b required 1", frame_start); end
      end else if ((k % DC) >= BC) begin
        checks++; if (digit_bin !== 4'((k / DC) % 8)) begin errors++; $display("FAIL old_data k=%0d got=%h required=%0d", k, digit_bin, (k / DC) % 8); end
      end
    end
    bus.load_req = 1'b0;
    checks++; if (!got) begin errors++; $display("FAIL load_ack_timeout: no ack required 1"); end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++; if (obs !== exp_vec) begin errors++; $display("FAIL load_new k=%0d got=%h required=%h", k, obs, exp_vec); end
      if ((k % FRAME) == BC) begin
        checks++; if (digit_bin !== 4'hF) begin errors++; $display("FAIL digit0_new: got %h required f", digit_bin); end
      end
      if ((k % FRAME) == 7 * DC + BC) begin
        checks++; if (digit_bin !== 4'hD) begin errors++; $display("FAIL digit7_new: got %h required d", digit_bin); end
      end
    end
  endtask

  task automatic test_leading_zeros;
    int lit;
    int hi;
    int dpc;
    logic [31:0] vals [3] = '{32'h00000120, 32'h00000000, 32'h00000120};
    logic [7:0]  dps  [3] = '{8'h00, 8'h00, 8'h10};
    int          want [3] = '{24, 8, 32};
    digit_en = 8'hFF;
    lz_blank = 1'b1;
    for (int t = 0; t < 3; t++) begin
      do_load(vals[t], dps[t]);
      lit = 0; hi = 0; dpc = 0;
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        checks++; if (obs !== exp_vec) begin errors++; $display("FAIL lz%0d k=%0d got=%h required=%h", t, k, obs, exp_vec); end
        if (Anode !== 8'hFF) lit++;
        if (Anode[7:3] !== 5'h1F && Anode[4] !== 1'b0) hi++;
        if (Anode === 8'hEF && dp_out === 1'b1 && digit_bin === 4'h0 && seg_blank === 1'b0) dpc++;
      end
      checks++; if (lit != want[t]) begin errors++; $display("FAIL lz_lit%0d: got %0d cycles required %0d", t, lit, want[t]); end
      checks++; if (hi != 0) begin errors++; $display("FAIL lz_high%0d: got %0d cycles required 0", t, hi); end
      if (t == 2) begin
        checks++; if (dpc != DC - BC) begin errors++; $display("FAIL lz_dp_override: got %0d cycles required %0d", dpc, DC - BC); end
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_enables;
    int hi = 0;
    int blanks = 0;
    lz_blank = 1'b0;
    digit_en = 8'h0F;
    do_load($urandom, 8'($urandom));
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++; if (obs !== exp_vec) begin errors++; $display("FAIL en k=%0d got=%h required=%h", k, obs, exp_vec); end
      if (Anode[7:4] !== 4'hF) hi++;
      if (seg_blank === 1'b1) blanks++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL en_high: got %0d cycles required 0", hi); end
    checks++; if (blanks != 8 * BC + 4 * (DC - BC)) begin errors++; $display("FAIL en_blank: got %0d cycles required %0d", blanks, 8 * BC + 4 * (DC - BC)); end
    digit_en = 8'hFF;
  endtask

  task automatic test_random;
    bit pending = 0;
    for (int c = 0; c < 5 * FRAME; c++) begin
      @(negedge clk);
      checks++; if (obs !== exp_vec) begin errors++; $display("FAIL rand k=%0d got=%h required=%h", k, obs, exp_vec); end
      if (pending && bus.load_ack === 1'b1) begin
        bus.load_req = 1'b0;
        pending = 0;
      end
      if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 23) == 0) lz_blank = 1'($urandom);
      if (!pending && $urandom_range(0, 59) == 0) begin
        bus.value_in = $urandom >> (4 * $urandom_range(0, 7));
        bus.dp_in = 8'($urandom) & 8'($urandom);
        bus.load_req = 1'b1;
        pending = 1;
      end
    end
    bus.load_req = 1'b0;
    digit_en = 8'hFF;
    lz_blank = 1'b0;
  endtask

  task automatic test_reset_mid;
    int fs = 0;
    for (int i = 0; i < 200 && (k % FRAME) != 5 * DC + 5; i++) @(negedge clk);
    bus.value_in = 32'h13579BDF;
    bus.dp_in = 8'h00;
    bus.load_req = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (Anode !== 8'hFF) begin errors++; $display("FAIL rst_mid_anode: got %h required ff", Anode); end
    checks++; if (bus.load_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b required 0", bus.load_ack); end
    checks++; if (seg_blank !== 1'b1) begin errors++; $display("FAIL rst_mid_blank: got %b required 1", seg_blank); end
    reset = 1'b1;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      checks++; if (obs !== exp_vec) begin errors++; $display("FAIL rst_run k=%0d got=%h required=%h", k, obs, exp_vec); end
      if (frame_start === 1'b1) fs++;
      if ((i % DC) >= BC) begin
        checks++; if (digit_bin !== 4'h0 || Anode !== ~(8'd1 << (i / DC))) begin errors++; $display("FAIL rst_cleared pos=%0d digit=%h anode=%h required 0 and %h", i, digit_bin, Anode, ~(8'd1 << (i / DC))); end
      end
    end
    checks++; if (fs != 0) begin errors++; $display("FAIL rst_frame_start: got %0d pulses required 0", fs); end
    @(negedge clk);
    checks++; if (bus.load_ack !== 1'b1 || frame_start !== 1'b1) begin errors++; $display("FAIL rst_first_load: ack=%b fs=%b required 1 1", bus.load_ack, frame_start); end
    bus.load_req = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++; if (obs !== exp_vec) begin errors++; $display("FAIL rst_after k=%0d got=%h required=%h", k, obs, exp_vec); end
    end
  endtask

  task automatic test_held_request;
    int acks = 0;
    int paired = 0;
    for (int i = 0; i < 200 && (k % FRAME) != 1; i++) @(negedge clk);
    bus.value_in = $urandom;
    bus.dp_in = 8'($urandom);
    bus.load_req = 1'b1;
    for (int i = 0; i < 330; i++) begin
      @(negedge clk);
      checks++; if (obs !== exp_vec) begin errors++; $display("FAIL held k=%0d got=%h required=%h", k, obs, exp_vec); end
      if (bus.load_ack === 1'b1) begin
        acks++;
        if (frame_start === 1'b1) paired++;
      end
      if (i == 3 * FRAME - 2) bus.load_req = 1'b0;
    end
    checks++; if (acks != 3) begin errors++; $display("FAIL held_acks: got %0d required 3", acks); end
    checks++; if (paired != 3) begin errors++; $display("FAIL held_paired: got %0d required 3", paired); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.value_in = 32'd0;
    bus.dp_in = 8'd0;
    bus.load_req = 1'b0;
    test_reset();
    test_scan_timing();
    test_load_timing();
    test_leading_zeros();
    test_enables();
    test_random();
    test_reset_mid();
    test_held_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Time-multiplexes the 8-digit common-anode seven-segment display on the board. It steps one digit at a time and drives the active-low Anode lines. For the active digit it presents a 4-bit nibble and a decimal-point bit to the existing binary-to-7-segment decoder, and it inserts a blanking gap between digits to prevent ghosting. A requester loads new display data through a req/ack handshake. Loads take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
DIGIT_CYCLES, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); must be > BLANK_CYCLES
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be >= 1
NUM_DIGITS, 8, digits scanned per frame; fixed at 8 for this board

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
value_in  input  32  eight packed nibbles; digit i = value_in[4i+3:4i]
dp_in  input  8  decimal-point enable per digit, active-high
digit_en  input  8  per-digit enable; 0 = digit always blank
lz_blank  input  1  1 = suppress leading zeros
load_req  input  1  request to load value_in/dp_in
load_ack  output  1  one-cycle pulse: load accepted
digit_bin  output  4  nibble for decoder
dp_out  output  1  decimal point for active digit, active-high
seg_blank  output  1  1 = decoder must force all segments off
Anode  output  8  active-low digit select; at most one bit low
frame_start  output  1  one-cycle pulse on the first cycle of digit 0's slot

Behaviour:
- Single clk domain. All outputs are registered. reset=0 sampled at a clk edge resets the block.
- Reset values: Anode=8'hFF, digit_bin=0, dp_out=0, seg_blank=1, load_ack=0, frame_start=0. Shadow value and dp registers clear to 0. Digit index=0, slot counter=0, state=BLANK.
- Slot counter runs 0..DIGIT_CYCLES-1, then wraps to 0 and the digit index advances (7 wraps to 0).
- FSM states:
  - BLANK: counter < BLANK_CYCLES; Anode=FF, seg_blank=1.
  - ON: remaining cycles of the slot.
  - Transitions: BLANK->ON when counter reaches BLANK_CYCLES; ON->BLANK at slot wrap.
- In ON for digit i:
  - Anode[i]=0, all other Anode bits 1.
  - digit_bin = shadow nibble i; dp_out = dp_shadow[i].
  - seg_blank=0 unless the digit is suppressed.
  - If the digit is suppressed, Anode stays FF for that slot as well.
- Suppression rules:
  - Digit i is suppressed if digit_en[i]=0.
  - With lz_blank=1, digit i is also suppressed when i > index of the most significant nonzero shadow nibble.
  - Digit 0 is never lz-suppressed, so value 0 shows a single "0".
  - A set dp_shadow bit on a digit overrides lz suppression for that digit.
- Load handshake:
  - Sampled only on the last cycle of digit 7's slot (the frame boundary).
  - If load_req=1 there: shadow<=value_in, dp_shadow<=dp_in, and load_ack=1 for exactly the next cycle.
  - That next cycle is also the frame_start cycle.
  - The requester holds value_in/dp_in stable while load_req=1 and drops load_req after the ack.
  - If load_req is still 1 after an ack, a second load occurs at the next frame boundary (no deduplication).
  - load_req=0 at the boundary: no load, shadow is unchanged.
- digit_en and lz_blank are sampled live every cycle; they are not shadowed.
- frame_start pulses when the index wraps 7->0. No pulse is generated on reset release.
- Reset mid-slot or mid-handshake: everything returns to reset values immediately and any pending request is dropped. The requester must re-assert load_req.
- Width rules: slot counter is $clog2(DIGIT_CYCLES) bits; digit index is 3 bits with natural wrap.

Decomposition:
- Shared package seg_pkg holds:
  - NUM_DIGITS=8
  - ANODE_OFF=8'hFF
  - scan state enum {BLANK, ON}
- One sub-module, seg_slot_timer: slot counter plus blank_done/slot_end strobes, parameterised by DIGIT_CYCLES and BLANK_CYCLES.
- Digit index, FSM, shadow registers and handshake stay in seg_scan_controller.

Test Plan:
- Scan timing: DIGIT_CYCLES=10, BLANK_CYCLES=2, digit_en=FF, lz_blank=0, one load of 32'h76543210.
  -> Each slot: 2 cycles Anode=FF, then 8 cycles with Anode=~(1<<i) and digit_bin=i.
  -> frame_start every 80 cycles.
- Load timing: load_req raised mid-frame with value_in=32'hDEADBEEF.
  -> load_ack pulses coincident with frame_start.
  -> digit 0 then shows F, digit 7 shows D.
  -> The current frame keeps the old data.
- Leading zeros: shadow=32'h00000120, lz_blank=1.
  -> Digits 0-2 shown (0,2,1); digits 3-7 Anode=FF, seg_blank=1.
  -> With shadow=0, only digit 0 is shown.
  -> With dp_in=8'h10 on a loaded 32'h00000120, digit 4 is shown as 0 with dp_out=1.
- Enables: digit_en=8'h0F.
  -> Anode never goes low for digits 4-7; timing of slots 4-7 is unchanged.
- Reset mid-operation: reset=0 during digit 5 ON with load_req=1.
  -> Next cycle Anode=FF, load_ack=0, shadow=0.
  -> After release, scan restarts at digit 0 with no frame_start pulse.
  -> Load happens at the first boundary after digit 7.
- Held request: load_req held high for 3 frames.
  -> Exactly 3 load_ack pulses, each coincident with frame_start.
